dial_tracker: RTL and testbench

- Streaming, parametrised successor to the day_1 dial solver.
- Consumes rotation records (direction plus amount) over a valid/ready channel instead of a fixed internal input. Tracks the dial position and reports a zero count when the last record retires.
- Selectable mode: count landings on 0 (part 1) or every click through 0 (part 2).
- Keeps the process/finished/result control contract used by the existing day benches.

---
 rtl/aoc_pkg.sv | 15 +
 rtl/dial_divmod.sv | 68 ++++++
 rtl/dial_tracker.sv | 167 ++++++++++++++++
 tb/tb_dial_tracker.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_pkg.sv
// Shared types for the dial tracker: controller state encoding and rotation direction codes.
package aoc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    DIV  = 3'd2,
    UPD  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/dial_divmod.sv
// Restoring divider by the constant DIAL_SIZE: one quotient bit per cycle, AMT_W cycles per
// division, then a single-cycle done pulse. A new start reloads it and restarts the division.
module dial_divmod #(
  parameter int AMT_W     = 16,
  parameter int DIAL_SIZE = 100
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [AMT_W-1:0]             dividend,
  output logic                         done,
  output logic [AMT_W-1:0]             quotient,
  output logic [$clog2(DIAL_SIZE)-1:0] remainder
);

  localparam int RW = $clog2(DIAL_SIZE);
  localparam int CW = $clog2(AMT_W + 1);
  localparam logic [RW:0] DIV_C = (RW + 1)'(DIAL_SIZE);

  logic [RW-1:0]    rem_q, rem_d;
  logic [AMT_W-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [RW:0]      trial;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    // quo_q doubles as the dividend shift register; quotient bits enter from the right
    trial  = {rem_q, quo_q[AMT_W-1]};
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      cnt_d = CW'(AMT_W);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
      if (trial >= DIV_C) begin
        rem_d = RW'(trial - DIV_C);
        quo_d = {quo_q[AMT_W-2:0], 1'b1};
      end else begin
        rem_d = trial[RW-1:0];
        quo_d = {quo_q[AMT_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/dial_tracker.sv
// Streaming dial tracker: applies rotation records to a dial position and counts zero
// landings (mode 0) or zero crossings (mode 1), saturating the count at its width.
//
//  state | meaning
//  IDLE  | waiting for process; position/result hold
//  RUN   | in_ready high, waiting for a record
//  DIV   | divider reducing the amount modulo DIAL_SIZE
//  UPD   | one cycle: apply new position and count
//  DONE  | last record retired, finished high until process drops
module dial_tracker
  import aoc_pkg::*;
#(
  parameter int DIAL_SIZE = 100,
  parameter int START_POS = 50,
  parameter int AMT_W     = 16,
  parameter int RESULT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         process,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_dir,
  input  logic [AMT_W-1:0]             in_amount,
  input  logic                         in_last,
  output logic                         busy,
  output logic                         finished,
  output logic [RESULT_W-1:0]          result,
  output logic [$clog2(DIAL_SIZE)-1:0] pos
);

  localparam int PW   = $clog2(DIAL_SIZE);
  localparam int SW   = PW + 1;
  localparam int IW   = AMT_W + 1;
  localparam int SUMW = ((RESULT_W > IW) ? RESULT_W : IW) + 1;
  localparam logic [SW-1:0]       D_X  = SW'(DIAL_SIZE);
  localparam logic [RESULT_W-1:0] RMAX = {RESULT_W{1'b1}};

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic                dir_q, dir_d;
  logic                last_q, last_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [RESULT_W-1:0] result_q, result_d;

  logic                div_start, div_done;
  logic [AMT_W-1:0]    quo;
  logic [PW-1:0]       rem;

  logic [SW-1:0]       pos_x, r_x, s_w, np_w;
  logic                wrap_r, wrap_l;
  logic [IW-1:0]       inc_w;
  logic [SUMW-1:0]     sum_w;
  logic [RESULT_W-1:0] sat_w;

  dial_divmod #(
    .AMT_W    (AMT_W),
    .DIAL_SIZE(DIAL_SIZE)
  ) u_divmod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (in_amount),
    .done     (div_done),
    .quotient (quo),
    .remainder(rem)
  );

  always_comb begin
    pos_x  = {1'b0, pos_q};
    r_x    = {1'b0, rem};
    s_w    = pos_x + r_x;
    wrap_r = (s_w >= D_X);
    // a left turn crosses 0 when it reaches or passes it, but starting on 0 is not a crossing
    wrap_l = (pos_q != '0) && (r_x >= pos_x);
    if (dir_q == DIR_R) begin
      np_w = wrap_r ? (s_w - D_X) : s_w;
    end else begin
      np_w = (r_x > pos_x) ? (pos_x + D_X - r_x) : (pos_x - r_x);
    end
    if (mode_q) begin
      inc_w = {1'b0, quo} + IW'((dir_q == DIR_R) ? wrap_r : wrap_l);
    end else begin
      inc_w = IW'(np_w == '0);
    end
    sum_w = SUMW'(result_q) + SUMW'(inc_w);
    sat_w = (sum_w > SUMW'(RMAX)) ? RMAX : sum_w[RESULT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    last_d    = last_q;
    pos_d     = pos_q;
    result_d  = result_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (process) begin
          state_d  = RUN;
          pos_d    = PW'(START_POS);
          result_d = '0;
          mode_d   = mode;
        end
      end
      RUN: begin
        if (!process) begin
          state_d = IDLE;
        end else if (in_valid) begin
          div_start = 1'b1;
          dir_d     = in_dir;
          last_d    = in_last;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (!process) begin
          state_d = IDLE;
        end else if (div_done) begin
          state_d = UPD;
        end
      end
      UPD: begin
        if (!process) begin
          state_d = IDLE;
        end else begin
          pos_d    = np_w[PW-1:0];
          result_d = sat_w;
          state_d  = last_q ? DONE : RUN;
        end
      end
      DONE: begin
        if (!process) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      dir_q    <= DIR_L;
      last_q   <= 1'b0;
      pos_q    <= PW'(START_POS);
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      last_q   <= last_d;
      pos_q    <= pos_d;
      result_q <= result_d;
    end
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == DIV) || (state_q == UPD);
  assign finished = (state_q == DONE);
  assign result   = result_q;
  assign pos      = pos_q;

endmodule

// File: tb/tb_dial_tracker.sv
// Bench for dial_tracker: a click-by-click dial model checked every cycle against a default
// instance and a 4-bit-result instance sharing the same stimulus.
module tb_dial_tracker;

  localparam int D  = 100;
  localparam int SP = 50;
  localparam int AW = 16;
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX4  = 15;

  logic clk = 1'b0, rst_n = 1'b1, process = 1'b0, mode = 1'b0;
  logic in_valid = 1'b0, in_dir = 1'b0, in_last = 1'b0;
  logic [AW-1:0] in_amount = '0;

  logic in_ready, busy, finished;
  logic [31:0] result;
  logic [6:0]  pos;
  logic s_in_ready, s_busy, s_finished;
  logic [3:0]  s_result;
  logic [6:0]  s_pos;

  dial_tracker dut (
    .clk(clk), .rst_n(rst_n), .process(process), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
    .in_amount(in_amount), .in_last(in_last), .busy(busy),
    .finished(finished), .result(result), .pos(pos)
  );

  dial_tracker #(.RESULT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .process(process), .mode(mode),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_dir(in_dir),
    .in_amount(in_amount), .in_last(in_last), .busy(s_busy),
    .finished(s_finished), .result(s_result), .pos(s_pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: dial moved one click at a time.
  function automatic int next_pos(input int p, input int amt, input bit dir);
    if (dir) return (p + amt) % D;
    return (p + D - (amt % D)) % D;
  endfunction

  function automatic longint zero_hits(input int p, input int amt, input bit dir, input bit md);
    int q = p;
    longint h = 0;
    if (!md) return (next_pos(p, amt, dir) == 0) ? 1 : 0;
    for (int i = 0; i < amt; i++) begin
      q = dir ? (q + 1) % D : (q + D - 1) % D;
      if (q == 0) h++;
    end
    return h;
  endfunction

  // phase: 0 idle, 1 accepting, 2 record in flight, 3 done
  int     m_phase = 0;
  int     m_wait  = 0;
  int     m_pos   = SP;
  longint m_cnt   = 0;
  bit     m_mode = 1'b0, m_dir = 1'b0, m_last = 1'b0;
  int     m_amt   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_pos <= SP; m_cnt <= 0; m_wait <= 0;
    end else begin
      case (m_phase)
        0: if (process) begin
             m_phase <= 1; m_pos <= SP; m_cnt <= 0; m_mode <= mode;
           end
        1: if (!process) m_phase <= 0;
           else if (in_valid) begin
             m_phase <= 2; m_wait <= AW + 1;
             m_dir <= in_dir; m_amt <= int'(in_amount); m_last <= in_last;
           end
        2: if (!process) m_phase <= 0;
           else if (m_wait == 0) begin
             m_pos   <= next_pos(m_pos, m_amt, m_dir);
             m_cnt   <= m_cnt + zero_hits(m_pos, m_amt, m_dir, m_mode);
             m_phase <= m_last ? 3 : 1;
           end else m_wait <= m_wait - 1;
        default: if (!process) m_phase <= 0;
      endcase
    end
  end

  int fin_cnt = 0;
  always @(negedge clk) begin
    fin_cnt <= fin_cnt + int'(finished);
    chk("in_ready", in_ready, (m_phase == 1) ? 1 : 0);
    chk("busy", busy, (m_phase == 1 || m_phase == 2) ? 1 : 0);
    chk("finished", finished, (m_phase == 3) ? 1 : 0);
    chk("result", result, (m_cnt > MAX32) ? MAX32 : m_cnt);
    chk("pos", pos, m_pos);
    chk("sat_finished", s_finished, (m_phase == 3) ? 1 : 0);
    chk("sat_result", s_result, (m_cnt > MAX4) ? MAX4 : m_cnt);
    chk("sat_pos", s_pos, m_pos);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit md);
    mode = md;
    process = 1'b1;
    tick();
  endtask

  task automatic end_run();
    process = 1'b0;
    tick();
    chk("finished_drop", finished, 0);
  endtask

  task automatic send(input bit dir, input int amt, input bit last, input int gapmax, input bit wait_done);
    int w;
    int n;
    repeat ($urandom_range(0, gapmax)) tick();
    in_dir = dir; in_amount = AW'(amt); in_last = last; in_valid = 1'b1;
    mode = 1'($urandom_range(0, 1));
    w = 0;
    while (!in_ready && w < 2000) begin tick(); w++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    if (!wait_done) return;
    n = 0;
    if (!last) begin
      do begin tick(); n++; end while (!in_ready && n < 100);
      chk("accept_to_ready", n, AW + 2);
    end else begin
      while (!finished && n < 100) begin tick(); n++; end
      chk("finished_timeout", finished, 1);
    end
  endtask

  bit ex_dir[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
  int ex_amt[10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};

  task automatic run_example(input bit md, input int gapmax);
    start_run(md);
    for (int i = 0; i < 10; i++) send(ex_dir[i], ex_amt[i], i == 9, gapmax, 1'b1);
  endtask

  initial begin
    int f0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_result", result, 0);
    chk("rst_pos", pos, 50);
    rst_n = 1'b1;
    tick();

    run_example(1'b0, 0);
    chk("ex_m0_result", result, 3);
    chk("ex_m0_pos", pos, 32);
    end_run();
    run_example(1'b1, 0);
    chk("ex_m1_result", result, 6);
    chk("ex_m1_pos", pos, 32);
    end_run();
    run_example(1'b0, 5);
    chk("ex_m0_gap_result", result, 3);
    end_run();
    run_example(1'b1, 5);
    chk("ex_m1_gap_result", result, 6);
    end_run();

    start_run(1'b1);
    send(1'b1, 1000, 1'b1, 0, 1'b1);
    chk("r1000_result", result, 10);
    chk("r1000_pos", pos, 50);
    end_run();
    start_run(1'b1);
    send(1'b0, 1000, 1'b1, 0, 1'b1);
    chk("l1000_result", result, 10);
    chk("l1000_pos", pos, 50);
    end_run();

    start_run(1'b1);
    send(1'b0, 50, 1'b0, 0, 1'b1);
    chk("l50_result", result, 1);
    chk("l50_pos", pos, 0);
    send(1'b0, 5, 1'b0, 0, 1'b1);
    chk("l5_result", result, 1);
    chk("l5_pos", pos, 95);
    send(1'b1, 5, 1'b1, 0, 1'b1);
    chk("r5_result", result, 2);
    chk("r5_pos", pos, 0);
    end_run();

    start_run(1'b0);
    send(1'b0, 50, 1'b0, 0, 1'b1);
    send(1'b1, 0, 1'b1, 0, 1'b1);
    chk("zero_amt_result", result, 2);
    chk("zero_amt_pos", pos, 0);
    end_run();

    start_run(1'b1);
    send(1'b1, 2000, 1'b1, 0, 1'b1);
    chk("sat_r2000", s_result, 15);
    chk("full_r2000", result, 20);
    end_run();

    f0 = fin_cnt;
    start_run(1'b0);
    send(ex_dir[0], ex_amt[0], 1'b0, 0, 1'b1);
    send(ex_dir[1], ex_amt[1], 1'b0, 0, 1'b1);
    send(ex_dir[2], ex_amt[2], 1'b0, 0, 1'b0);
    repeat (4) tick();
    process = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (25) tick();
    chk("abort_no_finish", fin_cnt - f0, 0);
    chk("abort_hold_pos", pos, 52);
    chk("abort_hold_result", result, 0);
    run_example(1'b0, 2);
    chk("restart_result", result, 3);
    end_run();

    start_run(1'b1);
    send(1'b1, 10, 1'b0, 0, 1'b0);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_finished", finished, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_pos", pos, 50);
    process = 1'b0;
    #3 rst_n = 1'b1;
    tick();

    for (int s = 0; s < 14; s++) begin
      int len;
      int cut;
      len = $urandom_range(1, 8);
      cut = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : len;
      start_run(1'($urandom_range(0, 1)));
      for (int i = 0; i < cut; i++) begin
        int a;
        int k;
        k = $urandom_range(0, 9);
        a = (k == 0) ? 0 : (k == 1) ? $urandom_range(1000, 3000) : $urandom_range(0, 250);
        send(1'($urandom_range(0, 1)), a, i == len - 1, 3, 1'b1);
      end
      repeat ($urandom_range(0, 6)) tick();
      end_run();
      repeat (20) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, elapsed %0t", $time);
    $fatal(1);
  end

endmodule
